scratch_pattern_gen: RTL and testbench

Parametrised, multi-mode test-pattern generator for the scratch core's video path. It replaces the fixed palette-grid generator. It takes H/V counters and blanking from the existing video timer and produces per-pixel RGB of configurable depth. Four selectable patterns are supported, plus a CPU-writable palette, per-frame horizontal scrolling and a frame counter. Output sits directly in front of the scaler/OSD, with blanking delayed to match the pixel pipeline.

---
 rtl/scratch_video_pkg.sv | 17 +
 rtl/jtframe_ram.sv | 38 +++
 rtl/scratch_pattern_gen.sv | 148 ++++++++++++++
 tb/tb_scratch_pattern_gen.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scratch_video_pkg.sv
// Shared definitions for the scratch core video path.
//   mode_e   : pattern select codes carried through the generator pipeline
//   PIPE_DLY : pixel-clock-enable latency from timer inputs to RGB output
//   FRAME_W  : width of the free-running frame counter
package scratch_video_pkg;

  typedef enum logic [1:0] {
    MODE_GRID  = 2'd0,
    MODE_BARS  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_GRAD  = 2'd3
  } mode_e;

  localparam int PIPE_DLY = 3;
  localparam int FRAME_W  = 8;

endpackage

// File: rtl/jtframe_ram.sv
// Palette-style RAM with an independent write port and a registered read port.
//   clk     : clock for both ports
//   cen     : read enable; q only updates on clk edges where cen is high
//   rd_addr : read address
//   q       : registered read data (old contents on same-address write)
//   we      : write strobe, honoured on every clk edge regardless of cen
//   wr_addr : write address
//   data    : write data
// Contents are not reset.
module jtframe_ram #(
  parameter int dw      = 8,
  parameter int aw      = 10,
  parameter     synfile = ""
) (
  input  logic          clk,
  input  logic          cen,
  input  logic [aw-1:0] rd_addr,
  output logic [dw-1:0] q,
  input  logic          we,
  input  logic [aw-1:0] wr_addr,
  input  logic [dw-1:0] data
);

  logic [dw-1:0] mem [0:(1<<aw)-1];

  // Preload image, when given, is attached by the implementation flow's
  // memory initialisation step; otherwise power-up contents are undefined.
  if (synfile != "") begin : g_preload
  end

  // Both updates are non-blocking, so a read of the address being written
  // in the same cycle returns the previous contents.
  always_ff @(posedge clk) begin
    if (we)  mem[wr_addr] <= data;
    if (cen) q <= mem[rd_addr];
  end

endmodule

// File: rtl/scratch_pattern_gen.sv
// Multi-mode test-pattern generator for the scratch core video path.
//   clk, rst        : 48 MHz clock, asynchronous active-low reset
//   pxl_cen         : pixel clock enable; the whole pixel pipeline advances on it
//   H, V            : horizontal / vertical counters from the video timer
//   LHBL, LVBL      : active-low blanking from the video timer
//   mode_in         : pattern select (grid, bars, checker, gradient), frame-latched
//   scroll_en       : per-frame horizontal scroll enable, frame-latched
//   pal_we/addr/din : palette write port {blue, green, red}, any clk
//   red/green/blue  : pixel colour, zero while blanked
//   LHBL_dly/LVBL_dly : blanking aligned with the colour outputs
//   frame_cnt       : frames seen since reset (LVBL falling edges)
module scratch_pattern_gen
  import scratch_video_pkg::*;
#(
  parameter int CW      = 4,
  parameter int TILE    = 4,
  parameter     SYNFILE = ""
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pxl_cen,
  input  logic [8:0]         H,
  input  logic [8:0]         V,
  input  logic               LHBL,
  input  logic               LVBL,
  input  logic [1:0]         mode_in,
  input  logic               scroll_en,
  input  logic               pal_we,
  input  logic [7:0]         pal_addr,
  input  logic [3*CW-1:0]    pal_din,
  output logic [CW-1:0]      red,
  output logic [CW-1:0]      green,
  output logic [CW-1:0]      blue,
  output logic               LHBL_dly,
  output logic               LVBL_dly,
  output logic [FRAME_W-1:0] frame_cnt
);

  function automatic logic [CW-1:0] fill(input logic b);
    return {CW{b}};
  endfunction

  // Zero-extended so the largest tile size can still take four index bits.
  function automatic logic [7:0] grid_addr(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] xe;
    logic [8:0] ye;
    xe = {1'b0, x};
    ye = {1'b0, y};
    return {ye[TILE+3:TILE], xe[TILE+3:TILE]};
  endfunction

  function automatic logic [3*CW-1:0] direct_rgb(input mode_e m, input logic [7:0] x,
                                                 input logic [7:0] y, input logic [7:0] f);
    logic [3*CW-1:0] c;
    c = '0;
    case (m)
      MODE_BARS:  c = {fill(x[7]), fill(x[6]), fill(x[5])};
      MODE_CHECK: c = {3{fill(x[TILE] ^ y[TILE])}};
      MODE_GRAD:  c = {f[7-:CW], y[7-:CW], x[7-:CW]};
      default:    c = '0;
    endcase
    return c;
  endfunction

  mode_e               mode_r;
  logic                scroll_r;
  logic                lvbl_last;
  logic [7:0]          hx;
  logic [7:0]          vy;
  mode_e               mode_p0, mode_p1;
  logic [7:0]          addr_p0;
  logic [3*CW-1:0]     rgb_p0, rgb_p1;
  logic [3*CW-1:0]     pal_q;
  logic [3*CW-1:0]     pix_p2;
  logic [PIPE_DLY-1:0] lhbl_sr, lvbl_sr;
  logic                unused_hv;

  assign unused_hv = H[8] ^ V[8];

  // Frame boundary: mode/scroll only change here, so a frame is never mixed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
      mode_r    <= MODE_GRID;
      scroll_r  <= 1'b0;
      lvbl_last <= 1'b0;
    end else if (pxl_cen) begin
      lvbl_last <= LVBL;
      if (lvbl_last && !LVBL) begin
        frame_cnt <= frame_cnt + 1'b1;
        mode_r    <= mode_e'(mode_in);
        scroll_r  <= scroll_en;
      end
    end
  end

  assign hx = H[7:0] + (scroll_r ? frame_cnt : 8'd0);
  assign vy = V[7:0];

  jtframe_ram #(
    .dw      (3*CW),
    .aw      (8),
    .synfile (SYNFILE)
  ) u_pal (
    .clk     (clk),
    .cen     (pxl_cen),
    .rd_addr (addr_p0),
    .q       (pal_q),
    .we      (pal_we),
    .wr_addr (pal_addr),
    .data    (pal_din)
  );

  // Blanking is judged on the stage-2 copy so it lands with the same pixel.
  assign pix_p2 = (lhbl_sr[PIPE_DLY-2] && lvbl_sr[PIPE_DLY-2]) ?
                  ((mode_p1 == MODE_GRID) ? pal_q : rgb_p1) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_p0 <= MODE_GRID;
      addr_p0 <= '0;
      rgb_p0  <= '0;
      mode_p1 <= MODE_GRID;
      rgb_p1  <= '0;
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      lhbl_sr <= '0;
      lvbl_sr <= '0;
    end else if (pxl_cen) begin
      // S1: effective coordinates -> palette address and direct colour
      mode_p0 <= mode_r;
      addr_p0 <= grid_addr(hx, vy);
      rgb_p0  <= direct_rgb(mode_r, hx, vy, frame_cnt);
      // S2: palette RAM read in flight, direct colour delayed to match
      mode_p1 <= mode_p0;
      rgb_p1  <= rgb_p0;
      // S3: source select, blanking, output register
      {blue, green, red} <= pix_p2;
      lhbl_sr <= {lhbl_sr[PIPE_DLY-2:0], LHBL};
      lvbl_sr <= {lvbl_sr[PIPE_DLY-2:0], LVBL};
    end
  end

  assign LHBL_dly = lhbl_sr[PIPE_DLY-1];
  assign LVBL_dly = lvbl_sr[PIPE_DLY-1];

endmodule

// File: tb/tb_scratch_pattern_gen.sv
module tb_scratch_pattern_gen;

  localparam int CW   = 4;
  localparam int TILE = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            pxl_cen = 1'b0;
  logic [8:0]      H = '0;
  logic [8:0]      V = '0;
  logic            LHBL = 1'b1;
  logic            LVBL = 1'b1;
  logic [1:0]      mode_in = '0;
  logic            scroll_en = 1'b0;
  logic            pal_we = 1'b0;
  logic [7:0]      pal_addr = '0;
  logic [3*CW-1:0] pal_din = '0;
  logic [CW-1:0]   red, green, blue;
  logic            LHBL_dly, LVBL_dly;
  logic [7:0]      frame_cnt;

  scratch_pattern_gen #(.CW(CW), .TILE(TILE), .SYNFILE("")) dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .H(H), .V(V), .LHBL(LHBL), .LVBL(LVBL),
    .mode_in(mode_in), .scroll_en(scroll_en), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_din(pal_din), .red(red), .green(green), .blue(blue),
    .LHBL_dly(LHBL_dly), .LVBL_dly(LVBL_dly), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int cmp_n = 0;
  int err_n = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int r, g, b;
    bit lh, lv;
    bit pending;
    int addr;
  } exp_t;

  int   m_frame, m_mode;
  bit   m_scroll, m_lvbl_last;
  int   pal_m [256];
  exp_t q [$];

  function automatic exp_t zero_exp();
    exp_t e;
    e.r = 0; e.g = 0; e.b = 0; e.lh = 0; e.lv = 0; e.pending = 0; e.addr = 0;
    return e;
  endfunction

  task automatic model_reset();
    m_frame = 0; m_mode = 0; m_scroll = 0; m_lvbl_last = 0;
    q.delete();
    q.push_back(zero_exp());
    q.push_back(zero_exp());
  endtask

  function automatic exp_t model_pix(input int h, input int v, input bit lh, input bit lv);
    exp_t e;
    int hx, vy, bar, c;
    e = zero_exp();
    e.lh = lh;
    e.lv = lv;
    hx = ((h % 256) + (m_scroll ? m_frame : 0)) % 256;
    vy = v % 256;
    if (lh && lv) begin
      case (m_mode)
        0: begin
          e.pending = 1;
          e.addr = ((vy >> TILE) % 16) * 16 + ((hx >> TILE) % 16);
        end
        1: begin
          bar = hx / 32;
          e.r = (bar % 2) ? MAXC : 0;
          e.g = ((bar / 2) % 2) ? MAXC : 0;
          e.b = ((bar / 4) % 2) ? MAXC : 0;
        end
        2: begin
          c = ((hx >> TILE) ^ (vy >> TILE)) % 2;
          e.r = c ? MAXC : 0; e.g = e.r; e.b = e.r;
        end
        default: begin
          e.r = hx >> (8 - CW);
          e.g = vy >> (8 - CW);
          e.b = m_frame >> (8 - CW);
        end
      endcase
    end
    return e;
  endfunction

  // One pixel-enable edge: the pixel accepted on the previous edge reads the
  // palette now (before any write on this same clock), then the new pixel enters.
  task automatic model_edge(input int h, input int v, input bit lh, input bit lv,
                            input bit wr, input int wa, input int wd, output exp_t out);
    exp_t t;
    if (q.size() > 0) begin
      t = q[q.size()-1];
      if (t.pending) begin
        t.r = pal_m[t.addr] & MAXC;
        t.g = (pal_m[t.addr] >> CW) & MAXC;
        t.b = (pal_m[t.addr] >> (2*CW)) & MAXC;
        t.pending = 0;
        q[q.size()-1] = t;
      end
    end
    if (wr) pal_m[wa] = wd;
    q.push_back(model_pix(h, v, lh, lv));
    if (m_lvbl_last && !lv) begin
      m_frame  = (m_frame + 1) % 256;
      m_mode   = int'(mode_in);
      m_scroll = scroll_en;
    end
    m_lvbl_last = lv;
    out = q.pop_front();
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic pix(input int h, input int v, input bit lh, input bit lv,
                     input bit wr = 0, input int wa = 0, input int wd = 0);
    exp_t e;
    logic [3*CW+1:0] ev;
    @(negedge clk);
    H = h[8:0]; V = v[8:0]; LHBL = lh; LVBL = lv; pxl_cen = 1'b1;
    pal_we = wr; pal_addr = wa[7:0]; pal_din = wd[3*CW-1:0];
    @(posedge clk);
    model_edge(h, v, lh, lv, wr, wa, wd, e);
    @(negedge clk);
    pxl_cen = 1'b0; pal_we = 1'b0;
    @(posedge clk);
    #1;
    ev = {e.r[CW-1:0], e.g[CW-1:0], e.b[CW-1:0], e.lh, e.lv};
    chk("pix_model", 32'({red, green, blue, LHBL_dly, LVBL_dly}), 32'(ev));
    chk("frame_cnt_model", 32'(frame_cnt), 32'(m_frame));
  endtask

  task automatic pal_wr(input int a, input int d);
    @(negedge clk);
    pal_we = 1'b1; pal_addr = a[7:0]; pal_din = d[3*CW-1:0];
    @(posedge clk);
    pal_m[a] = d;
    @(negedge clk);
    pal_we = 1'b0;
  endtask

  task automatic frame_pulse();
    pix(0, 0, 1, 0);
    pix(0, 0, 1, 1);
  endtask

  typedef struct {
    logic [1:0] mode;
    int         h, v;
    bit         lh;
    logic [3:0] r, g, b;
  } vec_t;

  vec_t vt [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur_mode;
    int hh, vv, wa, wd;
    bit lh, lv, wr;

    vt[0]  = '{2'd1, 'h000, 'h000, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[1]  = '{2'd1, 'h060, 'h000, 1'b1, 4'hF, 4'hF, 4'h0};
    vt[2]  = '{2'd1, 'h0A5, 'h000, 1'b1, 4'hF, 4'h0, 4'hF};
    vt[3]  = '{2'd1, 'h0FF, 'h000, 1'b1, 4'hF, 4'hF, 4'hF};
    vt[4]  = '{2'd2, 'h010, 'h000, 1'b1, 4'hF, 4'hF, 4'hF};
    vt[5]  = '{2'd2, 'h010, 'h010, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[6]  = '{2'd2, 'h000, 'h030, 1'b1, 4'hF, 4'hF, 4'hF};
    vt[7]  = '{2'd2, 'h02F, 'h020, 1'b1, 4'h0, 4'h0, 4'h0};
    vt[8]  = '{2'd3, 'h0A7, 'h03C, 1'b1, 4'hA, 4'h3, 4'h0};
    vt[9]  = '{2'd3, 'h012, 'h0F0, 1'b1, 4'h1, 4'hF, 4'h0};
    vt[10] = '{2'd3, 'h0A7, 'h03C, 1'b0, 4'h0, 4'h0, 4'h0};
    vt[11] = '{2'd1, 'h160, 'h000, 1'b1, 4'hF, 4'hF, 4'h0};

    // Reset with palette preload (RAM keeps contents through reset)
    #3 rst = 1'b0;
    model_reset();
    for (int a = 0; a < 256; a++) pal_wr(a, $urandom_range(0, 4095));
    repeat (10) @(posedge clk);
    #1;
    chk("reset_rgb", 32'({red, green, blue}), 32'h0);
    chk("reset_dly", 32'({LHBL_dly, LVBL_dly}), 32'h0);
    chk("reset_frame", 32'(frame_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    pix('h030, 'h010, 1, 1);
    chk("release_1_dly", 32'({LHBL_dly, LVBL_dly}), 32'h0);
    chk("release_1_rgb", 32'({red, green, blue}), 32'h0);
    pix('h040, 'h010, 1, 1);
    chk("release_2_dly", 32'({LHBL_dly, LVBL_dly}), 32'h0);
    pix('h050, 'h010, 1, 1);
    chk("release_3_dly", 32'({LHBL_dly, LVBL_dly}), 32'h3);
    chk("release_frame", 32'(frame_cnt), 32'h0);

    // Table of direct-colour patterns
    cur_mode = 0;
    for (int i = 0; i < 12; i++) begin
      if (int'(vt[i].mode) != cur_mode) begin
        mode_in = vt[i].mode;
        frame_pulse();
        cur_mode = int'(vt[i].mode);
      end
      repeat (3) pix(vt[i].h, vt[i].v, vt[i].lh, 1);
      chk($sformatf("vec%0d_rgb", i), 32'({red, green, blue}),
          32'({vt[i].r, vt[i].g, vt[i].b}));
    end

    // Scroll wrap in checker mode
    mode_in = 2'd2; scroll_en = 1'b1;
    for (int k = 0; k < 300 && m_frame != 16; k++) frame_pulse();
    chk("scroll_frame16", 32'(frame_cnt), 32'd16);
    repeat (3) pix('h0F0, 'h000, 1, 1);
    chk("scroll_wrap_black", 32'({red, green, blue}), 32'h000);
    repeat (3) pix('h0E0, 'h000, 1, 1);
    chk("scroll_white", 32'({red, green, blue}), 32'hFFF);
    repeat (240) frame_pulse();
    chk("frame_wrap", 32'(frame_cnt), 32'h0);

    // Palette read-during-write
    mode_in = 2'd0; scroll_en = 1'b0;
    frame_pulse();
    pal_wr('h21, 'h00A);
    pix('h010, 'h020, 1, 1);
    pix('h000, 'h000, 1, 1, 1, 'h21, 'h0F0);
    pix('h000, 'h000, 1, 1);
    chk("pal_old_value", 32'({red, green, blue}), 32'hA00);
    pix('h010, 'h020, 1, 1);
    pix('h000, 'h000, 1, 1);
    pix('h000, 'h000, 1, 1);
    chk("pal_new_value", 32'({red, green, blue}), 32'h0F0);

    // Mid-frame mode change takes effect at the next frame
    mode_in = 2'd3;
    repeat (3) pix('h035, 100, 1, 1);
    chk("midframe_grid", 32'(red), 32'(pal_m['h63] & MAXC));
    frame_pulse();
    repeat (3) pix('h05A, 'h000, 1, 1);
    chk("newframe_grad_red", 32'(red), 32'h5);
    chk("newframe_grad_green", 32'(green), 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 19) == 0) mode_in = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) scroll_en = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) pal_wr($urandom_range(0, 255), $urandom_range(0, 4095));
      hh = $urandom_range(0, 511);
      vv = $urandom_range(0, 511);
      lh = ($urandom_range(0, 7) != 0);
      lv = ($urandom_range(0, 29) != 0);
      wr = ($urandom_range(0, 7) == 0);
      wa = $urandom_range(0, 255);
      wd = $urandom_range(0, 4095);
      pix(hh, vv, lh, lv, wr, wa, wd);
    end

    // Asynchronous reset mid-stream
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("async_rst_dly", 32'({LHBL_dly, LVBL_dly}), 32'h0);
    chk("async_rst_frame", 32'(frame_cnt), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    mode_in = 2'd1;
    repeat (4) pix($urandom_range(0, 511), $urandom_range(0, 511), 1, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
